// File: rtl/vliw_pkg.sv
// Shared definitions for the VLIW bundler and the splitter side that unpacks bundles.
package vliw_pkg;

    localparam int          DEF_CORES    = 4;
    localparam int          DEF_INST_LEN = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    // FILL: collecting instructions; WAIT: bundle closed, waiting for the output register.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Lowest bit of a slot inside a packed bundle; slot i occupies [lsb +: inst_len].
    function automatic int slot_lsb(input int slot, input int inst_len);
        return slot * inst_len;
    endfunction

endpackage

// File: rtl/vliw_out_stage.sv
// Output register of the bundler: holds one bundle under a valid/ready handshake.
import vliw_pkg::*;

module vliw_out_stage #(
    parameter int                  cores    = DEF_CORES,
    parameter int                  inst_len = DEF_INST_LEN,
    parameter logic [inst_len-1:0] nop      = inst_len'(NOP_INST)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [inst_len*cores-1:0] data_in,
    input  logic [cores-1:0]          mask_in,
    input  logic                      vliw_ready,
    output logic [inst_len*cores-1:0] vliw_out,
    output logic [cores-1:0]          slot_mask,
    output logic                      vliw_valid,
    output logic                      free
);

    // The register may take a new bundle when empty or when its bundle leaves this cycle.
    assign free = !vliw_valid || vliw_ready;

    // Bundle register; contents only change on a load, which the bundler issues only when free.
    always_ff @(posedge clk) begin
        if (reset) begin
            vliw_out   <= {cores{nop}};
            slot_mask  <= {cores{1'b0}};
            vliw_valid <= 1'b0;
        end else if (load) begin
            vliw_out   <= data_in;
            slot_mask  <= mask_in;
            vliw_valid <= 1'b1;
        end else if (vliw_ready) begin
            vliw_valid <= 1'b0;
        end else begin
            vliw_valid <= vliw_valid;
        end
    end

endmodule

// File: rtl/vliw_bundler.sv
// Packs single instructions into VLIW bundles; emits when full or on flush, NOP-padding unused slots.
import vliw_pkg::*;

module vliw_bundler #(
    parameter int                  cores    = DEF_CORES,
    parameter int                  inst_len = DEF_INST_LEN,
    parameter logic [inst_len-1:0] nop      = inst_len'(NOP_INST)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [inst_len-1:0]          inst_in,
    input  logic                         inst_valid,
    output logic                         inst_ready,
    input  logic                         flush,
    output logic [inst_len*cores-1:0]    vliw_out,
    output logic [cores-1:0]             slot_mask,
    output logic                         vliw_valid,
    input  logic                         vliw_ready,
    output logic [$clog2(cores+1)-1:0]   fill_count
);

    localparam int CW = $clog2(cores + 1);

    state_t              state_r, state_s;
    logic [inst_len-1:0] buf_r    [cores];
    logic [inst_len-1:0] merged_s [cores];
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       n_s;
    logic                flush_pending_r;
    logic                accept_s;
    logic                close_s;
    logic                load_s;
    logic                free_s;
    logic [inst_len*cores-1:0] data_s;
    logic [cores-1:0]          mask_s;

    assign fill_count = count_r;

    // Accept/close decision, assembly merge and the NOP-padded bundle presented to the output stage.
    always_comb begin
        state_s    = state_r;
        merged_s   = buf_r;
        n_s        = count_r;
        close_s    = 1'b0;
        inst_ready = (state_r == FILL) && !reset;
        accept_s   = inst_valid && inst_ready;
        data_s     = {cores{nop}};
        mask_s     = {cores{1'b0}};

        case (state_r)
            FILL: begin
                if (accept_s) begin
                    for (int i = 0; i < cores; i++) begin
                        if (count_r == CW'(i)) begin
                            merged_s[i] = inst_in;
                        end else begin
                            merged_s[i] = buf_r[i];
                        end
                    end
                    n_s = count_r + CW'(1);
                end else begin
                    n_s = count_r;
                end
                // An empty flush is a no-op; a flush on the filling accept yields one full bundle.
                close_s = (n_s == CW'(cores)) || (flush && (n_s != CW'(0)));
                if (close_s && !free_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = FILL;
                end
            end
            WAIT: begin
                // Bundle is already closed; flush has nothing further to do here.
                close_s = 1'b1;
                n_s     = flush_pending_r ? count_r : CW'(cores);
                if (free_s) begin
                    state_s = FILL;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = FILL;
            end
        endcase

        load_s = close_s && free_s;

        for (int i = 0; i < cores; i++) begin
            if (CW'(i) < n_s) begin
                data_s[slot_lsb(i, inst_len) +: inst_len] = merged_s[i];
                mask_s[i] = 1'b1;
            end else begin
                data_s[slot_lsb(i, inst_len) +: inst_len] = nop;
                mask_s[i] = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FILL;
        end else begin
            state_r <= state_s;
        end
    end

    // Assembly buffer, slot count and latched flush reason for a partial bundle stuck in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < cores; i++) begin
                buf_r[i] <= nop;
            end
            count_r         <= CW'(0);
            flush_pending_r <= 1'b0;
        end else if (load_s) begin
            count_r         <= CW'(0);
            flush_pending_r <= 1'b0;
        end else if (close_s && (state_r == FILL)) begin
            buf_r           <= merged_s;
            count_r         <= n_s;
            flush_pending_r <= (n_s != CW'(cores));
        end else if (accept_s) begin
            buf_r   <= merged_s;
            count_r <= n_s;
        end else begin
            count_r <= count_r;
        end
    end

    vliw_out_stage #(
        .cores    (cores),
        .inst_len (inst_len),
        .nop      (nop)
    ) u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .data_in    (data_s),
        .mask_in    (mask_s),
        .vliw_ready (vliw_ready),
        .vliw_out   (vliw_out),
        .slot_mask  (slot_mask),
        .vliw_valid (vliw_valid),
        .free       (free_s)
    );

endmodule

// File: tb/tb_vliw_bundler.sv
// Scoreboard bench for vliw_bundler: expected bundles are queued at stimulus time, a monitor checks each consumed bundle.
module tb_vliw_bundler;

    logic         clk;
    logic         reset;
    logic [31:0]  inst_in;
    logic         inst_valid;
    logic         inst_ready;
    logic         flush;
    logic [127:0] vliw_out;
    logic [3:0]   slot_mask;
    logic         vliw_valid;
    logic         vliw_ready;
    logic [2:0]   fill_count;

    int checks;
    int errors;

    logic [127:0] exp_data_q [$];
    logic [3:0]   exp_mask_q [$];

    localparam logic [31:0] NOPW = 32'h0000_0000;

    vliw_bundler dut (
        .clk        (clk),
        .reset      (reset),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .flush      (flush),
        .vliw_out   (vliw_out),
        .slot_mask  (slot_mask),
        .vliw_valid (vliw_valid),
        .vliw_ready (vliw_ready),
        .fill_count (fill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bundle(input logic [31:0] s3, input logic [31:0] s2,
                                 input logic [31:0] s1, input logic [31:0] s0,
                                 input logic [3:0] m);
        exp_data_q.push_back({s3, s2, s1, s0});
        exp_mask_q.push_back(m);
    endtask

    // Drive a run of instructions on consecutive cycles, leaving inst_valid low afterwards.
    task automatic send4(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            inst_valid = 1'b1;
            inst_in    = base + 32'(i);
            cyc();
        end
        inst_valid = 1'b0;
    endtask

    // Monitor: every bundle the consumer takes must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && vliw_valid && vliw_ready) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle got %h mask %b expected none", vliw_out, slot_mask);
            end else begin
                check("bundle_data", vliw_out, exp_data_q.pop_front());
                check("bundle_mask", 128'(slot_mask), 128'(exp_mask_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog got timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        inst_in    = 32'h0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        vliw_ready = 1'b1;
        cyc();
        cyc();
        check("ready_in_reset", 128'(inst_ready), 128'(1'b0));
        reset = 1'b0;
        #1;
        check("rst_valid", 128'(vliw_valid), 128'(1'b0));
        check("rst_mask", 128'(slot_mask), 128'(4'b0000));
        check("rst_out", vliw_out, 128'h0);
        check("rst_fill", 128'(fill_count), 128'(3'd0));
        check("rst_ready", 128'(inst_ready), 128'(1'b1));

        // 1: four back-to-back instructions make one full bundle one cycle later.
        expect_bundle(32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            inst_valid = 1'b1;
            inst_in    = 32'hA000_0000 + 32'(i);
            #1;
            check("t1_ready", 128'(inst_ready), 128'(1'b1));
            cyc();
        end
        inst_valid = 1'b0;
        check("t1_valid", 128'(vliw_valid), 128'(1'b1));
        cyc();
        check("t1_valid_drop", 128'(vliw_valid), 128'(1'b0));

        // 2: partial bundle closed by flush.
        send4(32'hB000_0000, 2);
        expect_bundle(NOPW, NOPW, 32'hB000_0001, 32'hB000_0000, 4'b0011);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t2_valid", 128'(vliw_valid), 128'(1'b1));
        check("t2_fill", 128'(fill_count), 128'(3'd0));
        cyc();

        // 3: back-pressure; second bundle waits, first is held stable.
        vliw_ready = 1'b0;
        expect_bundle(32'hA100_0003, 32'hA100_0002, 32'hA100_0001, 32'hA100_0000, 4'b1111);
        send4(32'hA100_0000, 4);
        expect_bundle(32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000, 4'b1111);
        send4(32'hC000_0000, 4);
        check("t3_ready_low", 128'(inst_ready), 128'(1'b0));
        check("t3_fill4", 128'(fill_count), 128'(3'd4));
        cyc();
        check("t3_hold", vliw_out, {32'hA100_0003, 32'hA100_0002, 32'hA100_0001, 32'hA100_0000});
        check("t3_hold_valid", 128'(vliw_valid), 128'(1'b1));
        vliw_ready = 1'b1;
        cyc();
        vliw_ready = 1'b0;
        check("t3_valid_stays", 128'(vliw_valid), 128'(1'b1));
        check("t3_new_out", vliw_out, {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
        check("t3_ready_back", 128'(inst_ready), 128'(1'b1));
        check("t3_fill0", 128'(fill_count), 128'(3'd0));
        vliw_ready = 1'b1;
        cyc();
        check("t3_drained", 128'(vliw_valid), 128'(1'b0));

        // 4a: flush with nothing buffered does nothing.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t4_empty_valid", 128'(vliw_valid), 128'(1'b0));
        check("t4_empty_fill", 128'(fill_count), 128'(3'd0));
        check("t4_empty_ready", 128'(inst_ready), 128'(1'b1));

        // 4b: flush on the filling accept gives exactly one full bundle.
        send4(32'hD000_0000, 3);
        expect_bundle(32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000, 4'b1111);
        inst_valid = 1'b1;
        inst_in    = 32'hD000_0003;
        flush      = 1'b1;
        cyc();
        inst_valid = 1'b0;
        flush      = 1'b0;
        check("t4_valid", 128'(vliw_valid), 128'(1'b1));
        check("t4_mask", 128'(slot_mask), 128'(4'b1111));
        cyc();
        check("t4_no_extra", 128'(vliw_valid), 128'(1'b0));
        cyc();
        check("t4_no_extra2", 128'(vliw_valid), 128'(1'b0));

        // 5: reset discards a partial bundle.
        send4(32'hE000_0000, 3);
        reset = 1'b1;
        #1;
        check("t5_ready_rst", 128'(inst_ready), 128'(1'b0));
        cyc();
        reset = 1'b0;
        check("t5_valid", 128'(vliw_valid), 128'(1'b0));
        check("t5_fill", 128'(fill_count), 128'(3'd0));
        expect_bundle(32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000, 4'b1111);
        send4(32'hF000_0000, 4);
        cyc();

        // 6: flushed partial bundle waits behind a held bundle.
        vliw_ready = 1'b0;
        expect_bundle(32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000, 4'b1111);
        send4(32'h6000_0000, 4);
        send4(32'h7000_0000, 1);
        expect_bundle(NOPW, NOPW, NOPW, 32'h7000_0000, 4'b0001);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t6_ready_low", 128'(inst_ready), 128'(1'b0));
        check("t6_fill1", 128'(fill_count), 128'(3'd1));
        check("t6_hold", vliw_out, {32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
        vliw_ready = 1'b1;
        cyc();
        check("t6_out", vliw_out, {NOPW, NOPW, NOPW, 32'h7000_0000});
        check("t6_mask", 128'(slot_mask), 128'(4'b0001));
        check("t6_ready_back", 128'(inst_ready), 128'(1'b1));
        cyc();
        cyc();
        check("t6_drained", 128'(vliw_valid), 128'(1'b0));
        check("all_bundles_seen", 128'(exp_data_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
